conv_stage_sequencer: RTL and testbench
=======================================

CONV_STAGE_SEQUENCER -- requirements
Module: conv_stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of chained engines (conv / batchnorm_relu) sequenced; legal 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, max cycles a stage may run before fault; legal >= 2.
REQ-003 SHALL have parameter PERF_WIDTH, default 32, width of cycle counter.
REQ-004 SHALL use one clock and an asynchronous active-high reset; ports are clk and rst.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to run enabled stages.
REQ-008 abort  input  1  stop sequence, return to IDLE.
REQ-009 stage_mask  input  NUM_STAGES  per-stage enable; 0 = bypass.
REQ-010 stage_done  input  NUM_STAGES  per-stage done pulse/level from engines.
REQ-011 stage_start  output  NUM_STAGES  one-hot start pulse to engines.
REQ-012 stage_sel  output  clog2(NUM_STAGES) (min 1)  index of active stage, for valid/data muxing.
REQ-013 busy  output  1  sequence in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 error  output  1  sticky timeout flag.
REQ-016 err_stage  output  clog2(NUM_STAGES) (min 1)  stage that timed out.
REQ-017 run_cycles  output  PERF_WIDTH  cycles from start acceptance to done.

Function
REQ-018 States SHALL be IDLE, SEEK, LAUNCH, WAIT, FINISH, FAULT.
REQ-019 IDLE: start=1 -> capture stage_mask into mask_q, cur<=0, run_cycles<=0, clear error, go SEEK; start ignored in any other state except FAULT.
REQ-020 SEEK: cur==NUM_STAGES -> FINISH; mask_q[cur]=1 -> LAUNCH; else cur<=cur+1, stay SEEK (one stage skipped per cycle).
REQ-021 LAUNCH: stage_start[cur]=1 for exactly this one cycle, all other bits 0; timer<=0; go WAIT unconditionally; stage_done ignored in LAUNCH.
REQ-022 WAIT: stage_done[cur]=1 -> cur<=cur+1, go SEEK; stage_done bits of other indices ignored.
REQ-023 WAIT: timer increments each cycle; timer==TIMEOUT_CYCLES-1 with no stage_done[cur] -> error<=1, err_stage<=cur, go FAULT.
REQ-024 stage_done[cur] and timeout same cycle: done wins, no fault.
REQ-025 FINISH: done=1 for one cycle, go IDLE; run_cycles frozen at final value until next accepted start.
REQ-026 FAULT: error held; start=1 -> behaves as IDLE accept (REQ-019); abort=1 -> IDLE with error still held.
REQ-027 abort=1 in SEEK/LAUNCH/WAIT/FINISH -> IDLE next cycle, no done pulse, no stage_start; abort beats start, stage_done and timeout in same cycle.
REQ-028 mask_q all zero -> SEEK walks all NUM_STAGES indices then FINISH; done asserts NUM_STAGES+2 cycles after start cycle.
REQ-029 stage_mask changes after acceptance SHALL NOT affect the running sequence.
REQ-030 busy=1 in SEEK, LAUNCH, WAIT, FINISH; 0 in IDLE, FAULT.
REQ-031 run_cycles increments by 1 every cycle busy=1, saturates at all-ones.
REQ-032 stage_sel = cur while cur<NUM_STAGES, else NUM_STAGES-1; stage_start, done registered-state-decoded, glitch-free.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, cur=0, mask_q=0, timer=0, stage_start=0, stage_sel=0, busy=0, done=0, error=0, err_stage=0, run_cycles=0, including mid-sequence; first action after release only on a start.

Verification
REQ-034 NUM_STAGES=4, mask=4'b1111, each stage_done 5 cycles after its start -> four one-hot stage_start pulses in order 0..3, single done, run_cycles reported consistent with REQ-031.
REQ-035 mask=4'b0101 -> stage_start only bits 0 and 2; stage 1,3 skipped one cycle each in SEEK; stage_sel 0 then 2.
REQ-036 mask=0 -> no stage_start, done exactly 6 cycles after start (NUM_STAGES=4).
REQ-037 TIMEOUT_CYCLES=16, stage 1 never done -> error=1, err_stage=1, busy=0 after 16 WAIT cycles; new start clears error and reruns from stage 0.
REQ-038 abort asserted same cycle as stage_done[2] -> IDLE next cycle, no done, no stage_start[3]; done at timeout boundary -> no error.
REQ-039 rst pulsed during WAIT of stage 2 -> all outputs zero immediately; stray stage_done after release ignored.

Source files
------------

// File: rtl/conv_stage_sequencer.sv
// conv_stage_sequencer
//
// Walks a chain of NUM_STAGES processing engines (conv / batchnorm_relu),
// launching each enabled engine in turn and waiting for its done before
// moving on. Disabled stages are skipped at one cycle each. A stage that runs
// for TIMEOUT_CYCLES without reporting done raises a sticky error and parks
// the sequencer in FAULT until a new start or an abort arrives.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        one-cycle request to run the enabled stages (IDLE or FAULT)
//   abort        drop the running sequence and return to IDLE
//   stage_mask   per-stage enable captured at start; 0 = bypass
//   stage_done   per-stage done pulse/level from the engines
//   stage_start  one-hot launch pulse to the engines
//   stage_sel    index of the active stage, for valid/data muxing
//   busy         sequence in progress
//   done         one-cycle completion pulse
//   error        sticky timeout flag
//   err_stage    index of the stage that timed out
//   run_cycles   busy cycles since the last accepted start (saturating)

module conv_stage_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int PERF_WIDTH     = 32,
    localparam int SEL_W         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] stage_mask,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [SEL_W-1:0]      stage_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [SEL_W-1:0]      err_stage,
    output logic [PERF_WIDTH-1:0] run_cycles
);

    // cur must be able to hold NUM_STAGES itself, the "walked off the end" value
    localparam int CUR_W = $clog2(NUM_STAGES + 1);
    // timer only ever needs to reach TIMEOUT_CYCLES-1
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_LAUNCH,
        ST_WAIT,
        ST_FINISH,
        ST_FAULT
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [CUR_W-1:0]        cur;
    logic [SEL_W-1:0]        cur_idx;
    logic [NUM_STAGES-1:0]   mask_q;
    logic [TMR_W-1:0]        timer;
    logic                    cur_at_end;
    logic                    timed_out;
    logic                    accept;
    logic                    is_busy;

    // cur_idx is a safe array index: once cur has walked past the last stage it
    // pins to the last index so mask/done lookups never go out of range.
    assign cur_at_end = (cur == CUR_W'(NUM_STAGES));
    assign cur_idx    = cur_at_end ? SEL_W'(NUM_STAGES - 1) : cur[SEL_W-1:0];
    assign timed_out  = (timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign is_busy    = (state == ST_SEEK) || (state == ST_LAUNCH) ||
                        (state == ST_WAIT) || (state == ST_FINISH);
    // a start is accepted exactly when IDLE or FAULT is about to enter SEEK
    assign accept     = ((state == ST_IDLE) || (state == ST_FAULT)) && (state_n == ST_SEEK);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic. Abort has top priority in every busy state so that a
    // simultaneous done or timeout cannot sneak one more step through. In
    // FAULT an abort also beats a start, keeping the priority uniform.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start) state_n = ST_SEEK;
            end
            ST_SEEK: begin
                if (abort)                 state_n = ST_IDLE;
                else if (cur_at_end)       state_n = ST_FINISH;
                else if (mask_q[cur_idx])  state_n = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                if (abort) state_n = ST_IDLE;
                else       state_n = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort)                    state_n = ST_IDLE;
                else if (stage_done[cur_idx]) state_n = ST_SEEK;
                else if (timed_out)           state_n = ST_FAULT;
            end
            ST_FINISH: begin
                state_n = ST_IDLE;
            end
            ST_FAULT: begin
                if (abort)      state_n = ST_IDLE;
                else if (start) state_n = ST_SEEK;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Datapath: stage pointer, captured mask, per-stage watchdog, error capture
    // and the saturating performance counter. Updates key off the state
    // transition so they stay in lockstep with the FSM decisions above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur        <= '0;
            mask_q     <= '0;
            timer      <= '0;
            error      <= 1'b0;
            err_stage  <= '0;
            run_cycles <= '0;
        end else begin
            if (accept) begin
                mask_q     <= stage_mask;
                cur        <= '0;
                run_cycles <= '0;
                error      <= 1'b0;
            end else begin
                if (is_busy && (run_cycles != '1)) begin
                    run_cycles <= run_cycles + 1'b1;
                end
                // skipping a bypassed stage, or moving past a completed one
                if (((state == ST_SEEK) || (state == ST_WAIT)) && (state_n == ST_SEEK)) begin
                    cur <= cur + 1'b1;
                end
                if (state == ST_LAUNCH) begin
                    timer <= '0;
                end else if ((state == ST_WAIT) && (state_n == ST_WAIT)) begin
                    timer <= timer + 1'b1;
                end
                if ((state == ST_WAIT) && (state_n == ST_FAULT)) begin
                    error     <= 1'b1;
                    err_stage <= cur_idx;
                end
            end
        end
    end

    // Outputs decoded purely from registered state and pointer, so the launch
    // and done pulses carry no combinational path from the inputs.
    always_comb begin
        stage_start = '0;
        if (state == ST_LAUNCH) begin
            stage_start[cur_idx] = 1'b1;
        end
        stage_sel = cur_idx;
        busy      = is_busy;
        done      = (state == ST_FINISH);
    end

endmodule

// File: tb/tb_conv_stage_sequencer.sv
// tb_conv_stage_sequencer
//
// Scoreboard bench for conv_stage_sequencer (NUM_STAGES=4, TIMEOUT_CYCLES=16).
// Each directed scenario pushes its hand-computed launch/done events (stage
// index, cycle offset from the start cycle, final run_cycles) into a queue; an
// independent monitor pops and compares whenever the DUT pulses stage_start or
// done. A small engine model answers each launch after a per-stage latency.

module tb_conv_stage_sequencer;

    localparam int NS = 4;
    localparam int TO = 16;
    localparam int PW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [NS-1:0] stage_mask;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] stage_start;
    logic [1:0]    stage_sel;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_stage;
    logic [PW-1:0] run_cycles;

    logic [NS-1:0] eng_done = '0;
    logic [NS-1:0] man_done = '0;

    typedef struct {
        bit is_done;
        int idx;
        int rel;
        int run;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   c0           = 0;
    int   lat[NS]      = '{5, 5, 5, 5};
    int   cnt[NS]      = '{0, 0, 0, 0};

    assign stage_done = eng_done | man_done;

    conv_stage_sequencer #(
        .NUM_STAGES     (NS),
        .TIMEOUT_CYCLES (TO),
        .PERF_WIDTH     (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .stage_mask  (stage_mask),
        .stage_done  (stage_done),
        .stage_start (stage_start),
        .stage_sel   (stage_sel),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_stage   (err_stage),
        .run_cycles  (run_cycles)
    );

    // Free-running clock and cycle counter used for event timestamps
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issue a one-cycle start at the current negedge; returns at the negedge
    // one cycle later (offset 1, first SEEK cycle).
    task automatic applyStimulus(input logic [NS-1:0] mask);
        stage_mask = mask;
        start      = 1'b1;
        c0         = cyc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic pushStart(input int idx, input int rel);
        exp_t e;
        e.is_done = 1'b0;
        e.idx     = idx;
        e.rel     = rel;
        e.run     = 0;
        exp_q.push_back(e);
    endtask

    task automatic pushDone(input int rel, input int run);
        exp_t e;
        e.is_done = 1'b1;
        e.idx     = NS - 1;
        e.rel     = rel;
        e.run     = run;
        exp_q.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_stage_start"}, stage_start, 0);
        checkOutput({tag, "_stage_sel"},   stage_sel,   0);
        checkOutput({tag, "_busy"},        busy,        0);
        checkOutput({tag, "_done"},        done,        0);
        checkOutput({tag, "_error"},       error,       0);
        checkOutput({tag, "_err_stage"},   err_stage,   0);
        checkOutput({tag, "_run_cycles"},  run_cycles,  0);
    endtask

    // Engine model: a launch seen on stage i produces a one-cycle done pulse
    // lat[i] cycles later; lat 0 means the engine never answers.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NS; i++) begin
                eng_done[i] = (cnt[i] == 1);
                if (cnt[i] > 0) cnt[i]--;
                if (stage_start[i] && (lat[i] > 0)) cnt[i] = lat[i];
            end
        end
    end

    // Monitor: every launch or done pulse must match the head of the queue;
    // the frozen run_cycles value is checked the cycle after done.
    initial begin
        exp_t e;
        bit   run_pend;
        int   run_exp;
        run_pend = 1'b0;
        run_exp  = 0;
        forever begin
            @(negedge clk);
            if (run_pend) begin
                checkOutput("run_cycles_final", run_cycles, run_exp);
                run_pend = 1'b0;
            end
            if (stage_start != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_stage_start", stage_start, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_kind_start", 0, e.is_done);
                    checkOutput($sformatf("stage_start_onehot_%0d", e.idx), stage_start, 1 << e.idx);
                    checkOutput($sformatf("stage_sel_launch_%0d", e.idx), stage_sel, e.idx);
                    checkOutput($sformatf("launch_cycle_%0d", e.idx), cyc - c0, e.rel);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_kind_done", 1, e.is_done);
                    checkOutput("done_cycle", cyc - c0, e.rel);
                    checkOutput("stage_sel_at_done", stage_sel, NS - 1);
                    run_pend = 1'b1;
                    run_exp  = e.run;
                end
            end
        end
    end

    // Directed scenarios; offsets are cycles after the start cycle
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        stage_mask = '0;
        waitCycles(2);
        checkAllZero("reset");
        rst = 1'b0;
        waitCycles(3);
        checkOutput("idle_without_start_busy", busy, 0);

        // All four stages, 5-cycle engines; a stray start mid-run is ignored
        pushStart(0, 2); pushStart(1, 9); pushStart(2, 16); pushStart(3, 23);
        pushDone(30, 30);
        applyStimulus(4'b1111);
        checkOutput("full_busy_after_start", busy, 1);
        waitCycles(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitCycles(30);
        checkOutput("full_idle_busy", busy, 0);
        checkOutput("full_run_frozen", run_cycles, 30);
        checkOutput("full_queue_empty", exp_q.size(), 0);

        // Stages 0 and 2 only; mask changed right after acceptance
        pushStart(0, 2); pushStart(2, 10);
        pushDone(18, 18);
        applyStimulus(4'b0101);
        stage_mask = 4'b1010;
        waitCycles(24);
        checkOutput("mask0101_queue_empty", exp_q.size(), 0);

        // Stage 1 never answers: fault after 16 WAIT cycles
        lat = '{5, 0, 5, 5};
        pushStart(0, 2); pushStart(1, 9);
        applyStimulus(4'b1111);
        waitCycles(24);
        checkOutput("timeout_not_yet_error", error, 0);
        checkOutput("timeout_not_yet_busy", busy, 1);
        waitCycles(1);
        checkOutput("timeout_error", error, 1);
        checkOutput("timeout_err_stage", err_stage, 1);
        checkOutput("timeout_busy", busy, 0);
        waitCycles(3);
        checkOutput("timeout_error_sticky", error, 1);
        checkOutput("timeout_queue_empty", exp_q.size(), 0);

        // Restart directly from FAULT: error clears, full rerun from stage 0
        lat = '{5, 5, 5, 5};
        pushStart(0, 2); pushStart(1, 9); pushStart(2, 16); pushStart(3, 23);
        pushDone(30, 30);
        applyStimulus(4'b1111);
        checkOutput("restart_error_cleared", error, 0);
        checkOutput("restart_busy", busy, 1);
        waitCycles(34);
        checkOutput("restart_queue_empty", exp_q.size(), 0);

        // Fault on stage 1 alone, then abort out of FAULT keeps the error
        lat = '{5, 0, 5, 5};
        pushStart(1, 3);
        applyStimulus(4'b0010);
        waitCycles(19);
        checkOutput("fault2_error", error, 1);
        checkOutput("fault2_err_stage", err_stage, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("fault_abort_error_held", error, 1);
        checkOutput("fault_abort_busy", busy, 0);
        lat = '{5, 5, 5, 5};

        // Empty mask: pure walk, done six cycles after start
        pushDone(6, 6);
        applyStimulus(4'b0000);
        checkOutput("mask0_error_cleared", error, 0);
        waitCycles(10);
        checkOutput("mask0_queue_empty", exp_q.size(), 0);

        // Done lands exactly on the timeout boundary: done wins
        lat = '{16, 5, 5, 5};
        pushStart(0, 2);
        pushDone(23, 23);
        applyStimulus(4'b0001);
        waitCycles(25);
        checkOutput("boundary_no_error", error, 0);
        checkOutput("boundary_queue_empty", exp_q.size(), 0);

        // Abort together with stage_done[2]: no stage 3 launch, no done
        lat = '{5, 5, 0, 5};
        pushStart(0, 2); pushStart(1, 9); pushStart(2, 16);
        applyStimulus(4'b1111);
        waitCycles(18);
        man_done = 4'b0100;
        abort    = 1'b1;
        @(negedge clk);
        man_done = '0;
        abort    = 1'b0;
        checkOutput("abort_busy", busy, 0);
        waitCycles(15);
        checkOutput("abort_run_cycles", run_cycles, 19);
        checkOutput("abort_queue_empty", exp_q.size(), 0);

        // Reset in the middle of stage 2 WAIT, then stray dones are ignored
        lat = '{5, 5, 5, 5};
        pushStart(0, 2); pushStart(1, 9); pushStart(2, 16);
        applyStimulus(4'b1111);
        waitCycles(17);
        rst = 1'b1;
        #1;
        checkAllZero("midrun_reset");
        @(negedge clk);
        rst      = 1'b0;
        man_done = 4'b1111;
        @(negedge clk);
        man_done = '0;
        waitCycles(10);
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
